// File: rtl/bip_perif_ctrl.sv
// CPU-to-peripheral bridge: decodes a peripheral window onto N_PERIF chip-selected channels
// that share one tristate data bus. Each access waits for the channel ack or times out.
module bip_perif_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned N_PERIF    = 4,
  parameter int unsigned WAIT_MAX   = 15
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_req,
  input  logic                                  i_wr,
  input  logic [ADDR_WIDTH-1:0]                 i_addr,
  input  logic [DATA_WIDTH-1:0]                 i_wdata,
  output logic [DATA_WIDTH-1:0]                 o_rdata,
  output logic                                  o_stall,
  output logic                                  o_done,
  output logic                                  o_err,
  output logic [N_PERIF-1:0]                    o_cs_perif,
  output logic [ADDR_WIDTH-$clog2(N_PERIF)-1:0] o_addr_bus_per,
  output logic                                  o_w_r_per,
  input  logic [N_PERIF-1:0]                    i_ack,
  inout  wire  [DATA_WIDTH-1:0]                 io_per_data_bus
);

  localparam int unsigned SelW     = $clog2(N_PERIF);
  localparam int unsigned LocW     = ADDR_WIDTH - SelW;
  localparam logic [7:0]  LastWait = 8'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic [LocW-1:0]       laddr_q, laddr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [N_PERIF-1:0]    cs_q, cs_d;

  logic ack_sel;
  logic in_xfer;
  logic bus_oe;

  // Only the latched channel's ack counts; the others may toggle freely.
  assign ack_sel = i_ack[sel_q];
  assign in_xfer = (state_q == StSetup) || (state_q == StAccess);
  assign bus_oe  = in_xfer && wr_q;

  assign io_per_data_bus = bus_oe ? wdata_q : 'z;

  assign o_stall        = ((state_q == StIdle) && i_req) || in_xfer;
  assign o_rdata        = rdata_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_cs_perif     = cs_q;
  assign o_addr_bus_per = laddr_q;
  assign o_w_r_per      = wr_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    laddr_d = laddr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cs_d    = cs_q;

    unique case (state_q)
      StIdle: begin
        if (i_req) begin
          state_d = StSetup;
          sel_d   = i_addr[ADDR_WIDTH-1 -: SelW];
          laddr_d = i_addr[LocW-1:0];
          wr_d    = i_wr;
          wdata_d = i_wdata;
          // Chip select is registered, so it is decoded from the request being taken.
          cs_d    = '0;
          cs_d[i_addr[ADDR_WIDTH-1 -: SelW]] = 1'b1;
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = '0;
      end
      StAccess: begin
        if (ack_sel) begin
          state_d = StResp;
          done_d  = 1'b1;
          cs_d    = '0;
          if (!wr_q) begin
            rdata_d = io_per_data_bus;
          end
        end else if (cnt_q == LastWait) begin
          state_d = StResp;
          done_d  = 1'b1;
          err_d   = 1'b1;
          cs_d    = '0;
          if (!wr_q) begin
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      laddr_q <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      laddr_q <= laddr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
    end
  end

endmodule

// File: tb/tb_bip_perif_ctrl.sv
// Randomized bench for bip_perif_ctrl: stimulus pushes per-transfer expectations into a
// scoreboard; a negedge monitor compares every cycle against the head entry.
module tb_bip_perif_ctrl;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NP = 4;
  localparam int WM = 15;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          stall;
  logic          done;
  logic          err;
  logic [NP-1:0] cs;
  logic [LW-1:0] laddr;
  logic          w_r;
  logic [NP-1:0] ack;
  logic          per_drv;
  logic [DW-1:0] per_val;
  wire  [DW-1:0] bus;

  assign bus = per_drv ? per_val : 'z;

  bip_perif_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .N_PERIF   (NP),
    .WAIT_MAX  (WM)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_req          (req),
    .i_wr           (wr),
    .i_addr         (addr),
    .i_wdata        (wdata),
    .o_rdata        (rdata),
    .o_stall        (stall),
    .o_done         (done),
    .o_err          (err),
    .o_cs_perif     (cs),
    .o_addr_bus_per (laddr),
    .o_w_r_per      (w_r),
    .i_ack          (ack),
    .io_per_data_bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            issue;
    int            done_cyc;
    bit            abort;
    logic          err;
    logic [DW-1:0] rdata;
    logic [NP-1:0] cs;
    logic [LW-1:0] laddr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] pdata;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            rst_seen = 1'b0;
  logic [DW-1:0] model_rdata = '0;
  logic [DW-1:0] mon_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  // Monitor: reset cycles, idle cycles, in-flight cycles and the completion cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        chk("rst_cs", 32'(cs), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_laddr", 32'(laddr), 0);
        chk("rst_w_r", 32'(w_r), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_bus_released", 32'(bus), 32'(per_val));
        mon_rdata = '0;
        if (sb.size() != 0 && sb[0].abort) void'(sb.pop_front());
      end else begin
        if (sb.size() == 0) begin
          chk("idle_done", 32'(done), 0);
          chk("idle_cs", 32'(cs), 0);
        end else begin
          e = sb[0];
          if (cyc == e.done_cyc) begin
            chk("resp_done", 32'(done), 1);
            chk("resp_err", 32'(err), 32'(e.err));
            chk("resp_cs", 32'(cs), 0);
            chk("resp_stall", 32'(stall), 0);
            mon_rdata = e.rdata;
            void'(sb.pop_front());
          end else begin
            chk("busy_done", 32'(done), 0);
            chk("busy_stall", 32'(stall), 1);
            if (cyc == e.issue) begin
              chk("req_cs", 32'(cs), 0);
            end else begin
              chk("xfer_cs", 32'(cs), 32'(e.cs));
              chk("xfer_laddr", 32'(laddr), 32'(e.laddr));
              chk("xfer_w_r", 32'(w_r), 32'(e.wr));
              chk("xfer_bus", 32'(bus), e.wr ? 32'(e.wdata) : 32'(e.pdata));
            end
          end
        end
        chk("rdata", 32'(rdata), 32'(mon_rdata));
      end
    end
  end

  // dly >= WM means no ack (timeout); noise < 0 gives random acks on other channels;
  // abort_at >= 0 pulls reset in ACCESS cycle abort_at+1.
  task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                      input int dly, input logic [DW-1:0] pdata, input int noise,
                      input bit hold, input int abort_at);
    exp_t e;
    int   sel;
    int   last;
    bit   to;
    @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    sb.delete();
    sel        = int'(a[AW-1 -: 2]);
    to         = (dly >= WM) || (abort_at >= 0);
    e.issue    = cyc;
    e.abort    = (abort_at >= 0);
    e.done_cyc = e.abort ? cyc + 1000 : (to ? cyc + 2 + WM : cyc + 3 + dly);
    e.err      = to;
    e.cs       = 4'(1) << sel;
    e.laddr    = a[LW-1:0];
    e.wr       = w;
    e.wdata    = d;
    e.pdata    = pdata;
    if (!e.abort && !w) model_rdata = to ? '0 : pdata;
    e.rdata = model_rdata;
    sb.push_back(e);
    req     = 1'b1;
    wr      = w;
    addr    = a;
    wdata   = d;
    per_drv = !w;
    per_val = pdata;
    last    = e.abort ? e.issue + 2 + abort_at : e.done_cyc;
    while (cyc < last) begin
      @(posedge clk);
      #1;
      req   = hold;
      wr    = 1'($urandom);
      addr  = AW'($urandom);
      wdata = DW'($urandom);
      ack   = (noise < 0) ? NP'($urandom) : NP'(noise);
      ack[sel] = !to && (cyc == e.issue + 2 + dly);
    end
    if (e.abort) begin
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      per_val     = '0;
      model_rdata = '0;
    end
    per_drv = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      req = 1'b0;
      ack = NP'($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a_dly;
    int a_abort;
    rst_n   = 1'b0;
    req     = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    wdata   = '0;
    ack     = '0;
    per_drv = 1'b1;
    per_val = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    xfer(10'h2A5, 1'b1, 16'hBEEF, 1, 16'h0000, -1, 1'b0, -1);
    xfer(10'h013, 1'b0, 16'h0000, 0, 16'h1234, -1, 1'b0, -1);
    xfer(10'h3FF, 1'b0, 16'h0000, WM, 16'hCAFE, -1, 1'b0, -1);
    xfer(10'h2A5, 1'b0, 16'h0000, 5, 16'h5A5A, 4'b0010, 1'b0, -1);
    xfer(10'h255, 1'b1, 16'h1111, WM, 16'h0000, 4'b0010, 1'b0, -1);
    xfer(10'h1C3, 1'b1, 16'hA5A5, WM - 1, 16'h0000, -1, 1'b0, -1);
    xfer(10'h0C4, 1'b0, 16'h0000, WM - 1, 16'h9876, 4'b0111, 1'b0, -1);
    xfer(10'h2A5, 1'b1, 16'hBEEF, WM, 16'h0000, -1, 1'b0, 3);
    idle(2);
    xfer(10'h0AA, 1'b0, 16'h0000, 2, 16'h7777, -1, 1'b1, -1);
    xfer(10'h155, 1'b1, 16'h3333, 0, 16'h0000, -1, 1'b0, -1);

    for (int i = 0; i < 60; i++) begin
      a_dly   = $urandom_range(0, WM + 2);
      a_abort = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
      xfer(AW'($urandom), 1'($urandom), DW'($urandom), a_dly, DW'($urandom), -1,
           ($urandom_range(0, 4) == 0) && (a_abort < 0), a_abort);
      idle($urandom_range(0, 2));
    end

    @(posedge clk);
    #1;
    req = 1'b0;
    chk("sb_final", 32'(sb.size()), 0);
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
